// File: rtl/program_uploader.sv
// Program uploader: waits for the core's INIT byte, then sends the program
// size, the program words and (after the core's ACK) the input-data words
// over a byte-wide UART transmitter, reading the image from a 1-cycle ROM.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   start                     one-cycle pulse beginning an upload
//   prog_words, data_words    word counts, latched when start is accepted
//   rom_addr / rom_data       image ROM word address / read data (1-cycle latency)
//   rx_byte, rx_valid         byte stream from the UART receiver
//   tx_byte, tx_start, tx_busy  byte handshake with the UART transmitter
//   busy, done, error         upload status (done/error held until next start)
module program_uploader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 100000000,
  parameter logic [7:0]  INIT_BYTE = 8'h99,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_words,
  input  logic [ADDR_W-1:0] data_words,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_INIT, SEND_SIZE, SEND_PROG, WAIT_ACK, SEND_DATA, FINISH
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   prog_cnt;
  logic [ADDR_W-1:0]   data_cnt;
  logic [ADDR_W-1:0]   words_left;  // words still to send after the current one
  logic [31:0]         word_reg;
  logic [1:0]          byte_idx;
  logic [1:0]          fetch;       // 2: address presented, 1: capture rom_data
  logic                guard;       // cycle after tx_start, tx_busy not trusted
  logic                last_sent;   // final data byte issued, draining transmitter
  logic [WAIT_W-1:0]   wait_cnt;

  logic       can_issue;
  logic [7:0] cur_byte;

  assign can_issue = !tx_start && !guard && !tx_busy && (fetch == 2'd0);
  assign cur_byte  = word_reg[{byte_idx, 3'b000} +: 8];

  // Single-process FSM; the next word is fetched while the current word's
  // last byte is on the wire, so word boundaries add no idle cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      prog_cnt   <= '0;
      data_cnt   <= '0;
      words_left <= '0;
      word_reg   <= '0;
      byte_idx   <= '0;
      fetch      <= '0;
      guard      <= 1'b0;
      last_sent  <= 1'b0;
      wait_cnt   <= '0;
      rom_addr   <= '0;
      tx_byte    <= '0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      guard    <= tx_start;

      if (fetch == 2'd2) begin
        fetch <= 2'd1;
      end else if (fetch == 2'd1) begin
        word_reg <= rom_data;
        fetch    <= 2'd0;
      end

      case (state)
        IDLE, FINISH: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            prog_cnt  <= prog_words;
            data_cnt  <= data_words;
            wait_cnt  <= '0;
            last_sent <= 1'b0;
            state     <= WAIT_INIT;
          end
        end

        // A received byte outranks the timeout; an ignored byte defers it.
        WAIT_INIT: begin
          if (rx_valid && rx_byte == INIT_BYTE) begin
            word_reg <= 32'(prog_cnt);
            byte_idx <= 2'd0;
            state    <= SEND_SIZE;
          end else if (!rx_valid && wait_cnt == WAIT_W'(TIMEOUT)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end else if (wait_cnt != WAIT_W'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        SEND_SIZE, SEND_PROG, SEND_DATA: begin
          if (last_sent) begin
            if (!tx_start && !guard && !tx_busy) begin
              last_sent <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= FINISH;
            end
          end else if (can_issue) begin
            tx_start <= 1'b1;
            tx_byte  <= cur_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (state == SEND_SIZE && prog_cnt == '0) begin
                wait_cnt <= '0;
                state    <= WAIT_ACK;
              end else if (state == SEND_SIZE) begin
                rom_addr   <= '0;
                fetch      <= 2'd2;
                words_left <= prog_cnt - ADDR_W'(1);
                state      <= SEND_PROG;
              end else if (words_left == '0) begin
                if (state == SEND_PROG) begin
                  wait_cnt <= '0;
                  state    <= WAIT_ACK;
                end else begin
                  last_sent <= 1'b1;
                end
              end else begin
                rom_addr   <= rom_addr + ADDR_W'(1);
                fetch      <= 2'd2;
                words_left <= words_left - ADDR_W'(1);
              end
            end
          end
        end

        WAIT_ACK: begin
          if (rx_valid) begin
            if (rx_byte != ACK_BYTE) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= FINISH;
            end else if (data_cnt == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FINISH;
            end else begin
              rom_addr   <= prog_cnt;  // data image follows the program, mod 2^ADDR_W
              fetch      <= 2'd2;
              words_left <= data_cnt - ADDR_W'(1);
              byte_idx   <= 2'd0;
              state      <= SEND_DATA;
            end
          end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_uploader.sv
// Testbench for program_uploader: ROM and UART transmitter models, a byte
// capture monitor with handshake checks, and a reference model that derives
// the expected byte stream from the word counts and the ROM image.
module tb_program_uploader;

  localparam int unsigned AW    = 4;
  localparam int unsigned TO    = 50;
  localparam int unsigned ROM_D = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] prog_words = '0;
  logic [AW-1:0] data_words = '0;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data = '0;
  logic [7:0]    rx_byte = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_byte;
  logic          tx_start;
  logic          tx_busy;
  logic          busy;
  logic          done;
  logic          error;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [ROM_D];
  logic [7:0]  cap_q [$];
  int          cap_cyc [$];
  int          proto_viol = 0;
  int          busy_cnt = 0;
  int          busy_lo = 0;
  int          busy_hi = 0;
  int          cyc = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  held_byte = '0;

  program_uploader #(
    .ADDR_W(AW), .TIMEOUT(TO), .INIT_BYTE(8'h99), .ACK_BYTE(8'hAA)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .prog_words(prog_words),
    .data_words(data_words), .rom_addr(rom_addr), .rom_data(rom_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_byte(tx_byte),
    .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous image ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  assign tx_busy = (busy_cnt != 0);

  // Transmitter model and byte capture, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      busy_cnt   = 0;
      prev_start = 1'b0;
    end else begin
      if (tx_busy && tx_byte !== held_byte) begin
        proto_viol++;
        $display("protocol: tx_byte changed while busy at cycle %0d", cyc);
      end
      if (tx_start) begin
        if (tx_busy) begin
          proto_viol++;
          $display("protocol: tx_start while tx_busy at cycle %0d", cyc);
        end
        if (prev_start) begin
          proto_viol++;
          $display("protocol: tx_start longer than one cycle at cycle %0d", cyc);
        end
        cap_q.push_back(tx_byte);
        cap_cyc.push_back(cyc);
        held_byte = tx_byte;
        busy_cnt  = $urandom_range(busy_hi, busy_lo);
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      prev_start = tx_start;
    end
  end

  // Reference: byte k of an upload of p program words. Bytes 0..3 are the
  // size, then every image word w (program then data) is rom[w mod 2^AW].
  function automatic logic [7:0] exp_byte(input int p, input int k);
    logic [31:0] w;
    if (k < 4) w = 32'(p);
    else       w = rom[((k - 4) / 4) % ROM_D];
    return 8'(w >> (8 * (k % 4)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Waits for n captured bytes; optionally sprays rx bytes and start pulses
  // while the DUT is certainly still in a sending state.
  task automatic wait_bytes(input int base, input int n, input bit junk);
    int g = 0;
    while (cap_q.size() - base < n && g < 4000) begin
      if (junk && (cap_q.size() - base) <= n - 2 && $urandom_range(3, 0) == 0) begin
        rx_byte    = 8'($urandom);
        rx_valid   = 1'b1;
        start      = 1'($urandom_range(1, 0));
        prog_words = AW'($urandom);
      end
      tick();
      rx_valid = 1'b0;
      start    = 1'b0;
      g++;
    end
  endtask

  task automatic run_upload(input int p, input int d, input logic [7:0] ack,
                            input bit junk, output int base);
    int g;
    base = cap_q.size();
    prog_words = AW'(p);
    data_words = AW'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (junk) pulse_rx(8'h12);
    repeat ($urandom_range(5, 0)) tick();
    pulse_rx(8'h99);
    wait_bytes(base, 4 + 4 * p, junk);
    pulse_rx(ack);
    if (ack != 8'hAA) begin
      repeat (20) tick();
    end else begin
      if (d > 0) wait_bytes(base, 4 + 4 * p + 4 * d, junk);
      g = 0;
      while (!done && !error && g < 300) begin
        tick();
        g++;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (error !== 1'b0)   begin errors++; $display("FAIL reset_error got=%b want=0", error); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got=%h want=00", tx_byte); end
    checks++; if (rom_addr !== '0)  begin errors++; $display("FAIL reset_rom_addr got=%h want=0", rom_addr); end
    rstn = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_example();
    logic [7:0] expv [16] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                              8'h88, 8'h77, 8'h66, 8'h55, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    int base, v0;
    rom[0] = 32'h11223344;
    rom[1] = 32'h55667788;
    rom[2] = 32'h0A0B0C0D;
    busy_lo = 3; busy_hi = 3;
    v0 = proto_viol;
    run_upload(2, 1, 8'hAA, 1'b0, base);
    checks++;
    if (cap_q.size() - base !== 16) begin
      errors++; $display("FAIL example_count got=%0d want=16", cap_q.size() - base);
    end
    for (int k = 0; k < 16 && base + k < cap_q.size(); k++) begin
      checks++;
      if (cap_q[base + k] !== expv[k]) begin
        errors++; $display("FAIL example_byte[%0d] got=%h want=%h", k, cap_q[base + k], expv[k]);
      end
    end
    checks++; if (done !== 1'b1)  begin errors++; $display("FAIL example_done got=%b want=1", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL example_error got=%b want=0", error); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL example_busy got=%b want=0", busy); end
    checks++; if (proto_viol - v0 !== 0) begin errors++; $display("FAIL example_protocol got=%0d want=0", proto_viol - v0); end
  endtask

  task automatic test_zero_words();
    int base;
    busy_lo = 0; busy_hi = 2;
    run_upload(0, 0, 8'hAA, 1'b0, base);
    repeat (10) tick();
    checks++;
    if (cap_q.size() - base !== 4) begin
      errors++; $display("FAIL zero_count got=%0d want=4", cap_q.size() - base);
    end
    for (int k = 0; k < 4 && base + k < cap_q.size(); k++) begin
      checks++;
      if (cap_q[base + k] !== 8'h00) begin
        errors++; $display("FAIL zero_byte[%0d] got=%h want=00", k, cap_q[base + k]);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_held got=%b want=1", done); end
  endtask

  task automatic test_timeout();
    int base, g;
    busy_lo = 2; busy_hi = 2;
    prog_words = AW'(1);
    data_words = AW'(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL start_clears_done got=%b want=0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_sets_busy got=%b want=1", busy); end
    repeat (TO) tick();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b want=0", error); end
    tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_init got=%b want=1", error); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL timeout_busy got=%b want=0", busy); end

    // Byte arriving in the timeout cycle wins; then WAIT_ACK times out
    base = cap_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL start_clears_error got=%b want=0", error); end
    repeat (TO) tick();
    pulse_rx(8'h99);
    wait_bytes(base, 8, 1'b0);
    g = 0;
    while (!error && g < 200) begin
      tick();
      g++;
    end
    repeat (10) tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_ack got=%b want=1", error); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL timeout_ack_done got=%b want=0", done); end
    checks++;
    if (cap_q.size() - base !== 8) begin
      errors++; $display("FAIL timeout_edge_count got=%0d want=8", cap_q.size() - base);
    end
    for (int k = 0; k < 8 && base + k < cap_q.size(); k++) begin
      checks++;
      if (cap_q[base + k] !== exp_byte(1, k)) begin
        errors++; $display("FAIL timeout_edge_byte[%0d] got=%h want=%h", k, cap_q[base + k], exp_byte(1, k));
      end
    end
  endtask

  task automatic test_nack();
    int base, v0;
    busy_lo = 0; busy_hi = 2;
    v0 = proto_viol;
    run_upload(1, 2, 8'h55, 1'b1, base);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL nack_error got=%b want=1", error); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL nack_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL nack_busy got=%b want=0", busy); end
    checks++;
    if (cap_q.size() - base !== 8) begin
      errors++; $display("FAIL nack_count got=%0d want=8", cap_q.size() - base);
    end
    for (int k = 0; k < 8 && base + k < cap_q.size(); k++) begin
      checks++;
      if (cap_q[base + k] !== exp_byte(1, k)) begin
        errors++; $display("FAIL nack_byte[%0d] got=%h want=%h", k, cap_q[base + k], exp_byte(1, k));
      end
    end
    checks++; if (proto_viol - v0 !== 0) begin errors++; $display("FAIL nack_protocol got=%0d want=0", proto_viol - v0); end
  endtask

  task automatic test_random();
    int base, p, d, n, v0;
    for (int it = 0; it < 6; it++) begin
      p = $urandom_range(ROM_D - 1, 0);
      d = $urandom_range(ROM_D - 1, 0);
      busy_lo = 0;
      busy_hi = $urandom_range(6, 0);
      v0 = proto_viol;
      run_upload(p, d, 8'hAA, 1'b1, base);
      n = 4 + 4 * (p + d);
      checks++;
      if (cap_q.size() - base !== n) begin
        errors++; $display("FAIL random%0d_count p=%0d d=%0d got=%0d want=%0d", it, p, d, cap_q.size() - base, n);
      end
      for (int k = 0; k < n && base + k < cap_q.size(); k++) begin
        checks++;
        if (cap_q[base + k] !== exp_byte(p, k)) begin
          errors++; $display("FAIL random%0d_byte[%0d] got=%h want=%h", it, k, cap_q[base + k], exp_byte(p, k));
        end
      end
      checks++; if (done !== 1'b1)  begin errors++; $display("FAIL random%0d_done got=%b want=1", it, done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL random%0d_error got=%b want=0", it, error); end
      checks++; if (proto_viol - v0 !== 0) begin errors++; $display("FAIL random%0d_protocol got=%0d want=0", it, proto_viol - v0); end
    end
  endtask

  task automatic test_busy_hold();
    int base, v0, gap, tgt;
    busy_lo = 10; busy_hi = 10;
    v0 = proto_viol;
    run_upload(3, 2, 8'hAA, 1'b0, base);
    tgt = 4 + 4 * 3;
    checks++;
    if (cap_q.size() - base !== 24) begin
      errors++; $display("FAIL hold_count got=%0d want=24", cap_q.size() - base);
    end
    for (int k = 0; k < 24 && base + k < cap_q.size(); k++) begin
      checks++;
      if (cap_q[base + k] !== exp_byte(3, k)) begin
        errors++; $display("FAIL hold_byte[%0d] got=%h want=%h", k, cap_q[base + k], exp_byte(3, k));
      end
    end
    // Spacing within the size+program and data phases: 10 busy + guard .. +2 idle
    for (int k = 1; k < 24 && base + k < cap_cyc.size(); k++) begin
      if (k != tgt) begin
        gap = cap_cyc[base + k] - cap_cyc[base + k - 1];
        checks++;
        if (gap < 11 || gap > 13) begin
          errors++; $display("FAIL hold_gap[%0d] got=%0d want=11..13", k, gap);
        end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done got=%b want=1", done); end
    checks++; if (proto_viol - v0 !== 0) begin errors++; $display("FAIL hold_protocol got=%0d want=0", proto_viol - v0); end
  endtask

  task automatic test_reset_mid();
    int base, g, n0;
    busy_lo = 4; busy_hi = 4;
    base = cap_q.size();
    prog_words = AW'(8);
    data_words = AW'(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_rx(8'h99);
    wait_bytes(base, 6, 1'b0);
    g = 0;
    while (tx_start !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start got=%b want=0", tx_start); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL midrst_tx_byte got=%h want=00", tx_byte); end
    checks++; if (rom_addr !== '0)   begin errors++; $display("FAIL midrst_rom_addr got=%h want=0", rom_addr); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL midrst_done got=%b want=0", done); end
    checks++; if (error !== 1'b0)    begin errors++; $display("FAIL midrst_error got=%b want=0", error); end
    repeat (2) tick();
    rstn = 1'b1;
    n0 = cap_q.size();
    pulse_rx(8'h99);
    repeat (20) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle got=%b want=0", busy); end
    checks++;
    if (cap_q.size() !== n0) begin
      errors++; $display("FAIL midrst_no_tx got=%0d want=%0d", cap_q.size(), n0);
    end
  endtask

  initial begin
    for (int i = 0; i < ROM_D; i++) rom[i] = $urandom;
    test_reset();
    test_example();
    test_zero_words();
    test_timeout();
    test_nack();
    test_random();
    test_busy_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
